// File: rtl/mem_req_responder.sv
// Arbitrates instruction-fetch and data-memory requests onto one single-port RAM handshake.
// Each granted access is held until ramready or timeout, then answered with a one-cycle hit.
//
// state | meaning
// IDLE  | no access in flight; requests sampled and granted here
// DACC  | data access driven onto the RAM, waiting for ramready
// IACC  | instruction read driven onto the RAM, waiting for ramready
// RESP  | one-cycle iHit/dHit for the access that just finished
module mem_req_responder #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] iload,
  output logic              iHit,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic [DATA_W-1:0] dload,
  output logic              dHit,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ramready,
  output logic              timeout_err,
  output logic              proto_err
);

  typedef enum logic [1:0] {IDLE, DACC, IACC, RESP} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              write_q;
  logic              resp_i_q;
  logic              last_data;
  logic [7:0]        cnt;
  logic [DATA_W-1:0] iload_q, dload_q;
  logic              timeout_q, proto_q;

  logic              d_req, grant_d, grant_i, tmo_hit;

  assign d_req   = dREN | dWEN;
  assign tmo_hit = (cnt == TMO_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Fetch wins a tie only when the previous grant went to data, so neither side starves.
  always_comb begin
    state_nxt = state;
    grant_d   = 1'b0;
    grant_i   = 1'b0;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    iHit      = 1'b0;
    dHit      = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && !(iREN && last_data)) begin
          grant_d   = 1'b1;
          state_nxt = DACC;
        end else if (iREN) begin
          grant_i   = 1'b1;
          state_nxt = IACC;
        end
      end
      DACC, IACC: begin
        ramREN = !write_q;
        ramWEN = write_q;
        if (ramready || tmo_hit) state_nxt = RESP;
      end
      RESP: begin
        iHit      = resp_i_q;
        dHit      = !resp_i_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      resp_i_q  <= 1'b0;
      last_data <= 1'b0;
      cnt       <= '0;
      iload_q   <= '0;
      dload_q   <= '0;
      timeout_q <= 1'b0;
      proto_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            addr_q    <= daddr;
            wdata_q   <= dstore;
            write_q   <= dWEN;
            resp_i_q  <= 1'b0;
            last_data <= 1'b1;
            cnt       <= '0;
            if (dREN && dWEN) proto_q <= 1'b1;
          end else if (grant_i) begin
            addr_q    <= iaddr;
            write_q   <= 1'b0;
            resp_i_q  <= 1'b1;
            last_data <= 1'b0;
            cnt       <= '0;
          end
        end
        DACC, IACC: begin
          if (ramready) begin
            if (resp_i_q)      iload_q <= ramload;
            else if (!write_q) dload_q <= ramload;
          end else if (tmo_hit) begin
            // Aborted access still answers with a hit so the pipeline keeps moving.
            timeout_q <= 1'b1;
            if (resp_i_q) iload_q <= '0;
            else          dload_q <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ramaddr     = addr_q;
  assign ramstore    = wdata_q;
  assign iload       = iload_q;
  assign dload       = dload_q;
  assign timeout_err = timeout_q;
  assign proto_err   = proto_q;

endmodule

// File: doc/mem_req_responder.md
Name: mem_req_responder

Overview:
- Responder for the data-memory request interface driven by the execute/memory pipeline register (dREN/dWEN/address/store data).
- Also serves the instruction-fetch request.
- Arbitrates both requesters onto one single-port RAM handshake, holds each granted request until the RAM completes, and returns a one-cycle iHit/dHit with registered load data.
- Sits between the pipeline latches and the RAM model. It produces the hit strobes that advance the pipeline registers.

Parameters:
- ADDR_W, 32, address width for iaddr/daddr/ramaddr.
- DATA_W, 32, data width for all load/store buses.
- TIMEOUT, 64, maximum cycles in an access state without ramready before abort; legal range 2..255.

Ports:
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous, active-high reset
- iREN  in  1  instruction read request; held high by requester until iHit
- iaddr  in  ADDR_W  instruction address
- iload  out  DATA_W  instruction read data; valid in the iHit cycle
- iHit  out  1  one-cycle instruction completion strobe
- dREN  in  1  data read request; held until dHit
- dWEN  in  1  data write request; held until dHit
- daddr  in  ADDR_W  data address
- dstore  in  DATA_W  data write value
- dload  out  DATA_W  data read value; valid in the dHit cycle
- dHit  out  1  one-cycle data completion strobe
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  DATA_W  RAM write data
- ramload  in  DATA_W  RAM read data; valid when ramready=1
- ramready  in  1  RAM completion, one cycle per access
- timeout_err  out  1  sticky abort flag
- proto_err  out  1  sticky flag: dREN and dWEN both high when sampled

Behaviour:
- Reset (async, RST=1):
  - state=IDLE, last_data=0, timeout counter=0.
  - All outputs 0: iHit, dHit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, timeout_err, proto_err.
  - Reset mid-access drops the access immediately. The RAM strobes fall asynchronously.
- State machine: IDLE, DACC, IACC, RESP.
- IDLE grant rule, sampled at the clock edge:
  - A data request is dREN|dWEN.
  - Data request only -> DACC.
  - iREN only -> IACC.
  - Both pending: IACC if last_data=1, else DACC. This prevents fetch starvation after back-to-back data accesses.
  - On grant, latch address, store data and operation, and set last_data to the granted side.
- Granted operation:
  - dWEN&dREN together -> write wins and proto_err sets (sticky).
  - IACC always reads.
- DACC/IACC:
  - ramREN or ramWEN asserted from the cycle after grant, driven from the latched address/data.
  - Inputs may change without effect.
  - Counter increments each cycle.
- ramready=1 in DACC/IACC:
  - Deassert the RAM strobes and go to RESP.
  - Capture ramload into dload (data read) or iload (instruction). A data write leaves dload unchanged.
- RESP (exactly 1 cycle):
  - The corresponding hit is 1. Then go to IDLE.
  - Requests are not sampled in RESP; the requester drops or changes its request on the hit edge.
- Timing:
  - Minimum latency from request sampled at edge N: RAM strobes N+1, ramready N+1, hit N+2.
  - Back-to-back grant spacing: one IDLE cycle.
- Timeout:
  - Counter reaching TIMEOUT without ramready -> deassert strobes, set timeout_err (sticky), go to RESP.
  - Hit is still issued so the pipeline is not deadlocked; load output is 0.
  - Counter clears on entering DACC/IACC.
- Other rules:
  - ramready outside DACC/IACC is ignored.
  - iHit and dHit are never high together.

Test Plan:
- Reset during DACC with ramWEN=1 -> ramWEN, dHit and all flags 0 immediately; state IDLE after release; next dREN served normally.
- dREN=1, daddr=0x40, RAM returns 0xDEADBEEF with ramready two cycles after ramREN -> ramREN with ramaddr=0x40 for 2 cycles, then dHit=1 for 1 cycle with dload=0xDEADBEEF.
- dWEN=1, daddr=0x80, dstore=0x12345678, ramready on first strobe cycle -> ramWEN=1, ramstore=0x12345678 for 1 cycle; dHit exactly 2 cycles after request sample.
- iREN and dREN both held continuously with zero-wait RAM -> grants alternate D, I, D, I; no two consecutive D grants while iREN pending; iHit/dHit never coincident.
- dREN&dWEN both 1 -> write performed, proto_err=1 and stays 1 until RST.
- ramready tied 0 with TIMEOUT=8, iREN=1 -> ramREN deasserts after 8 cycles, iHit=1 with iload=0, timeout_err=1 sticky.
